mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port between the multicycle
//  CPU (port 0: fetch, LDR, STR) and a DMA/loader engine (port 1).

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU (port 0) and a DMA engine (port 1).
// One transfer at a time: IDLE -> BUSY (memory access, watchdog) -> RESP (done pulse) -> IDLE.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_adr,
    input  logic [DW-1:0] p0_wd,
    output logic          p0_done,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_adr,
    input  logic [DW-1:0] p1_wd,
    output logic          p1_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    input  logic          mem_ack,
    output logic          owner
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Handshake: a requester holds req until its done pulse; done lasts exactly one
    // cycle (RESP) and the requester drops or changes req on the edge ending it.
    state_t        state;
    state_t        state_next;
    logic          last;
    logic          win;
    logic          grant;
    logic          timeout_hit;
    logic          lat_we;
    logic [CW-1:0] cnt;

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        win        = 1'b0;
        grant      = 1'b0;
        mem_en     = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    win        = 1'b1;
                    // On a tie the port that did not win last time gets the grant.
                    grant      = (p0_req && p1_req) ? ~last : p1_req;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_en = 1'b1;
                if (mem_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner   <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            lat_we  <= 1'b0;
            mem_adr <= '0;
            mem_wd  <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            if (win) begin
                owner   <= grant;
                last    <= grant;
                cnt     <= '0;
                lat_we  <= grant ? p1_we  : p0_we;
                mem_adr <= grant ? p1_adr : p0_adr;
                mem_wd  <= grant ? p1_wd  : p0_wd;
            end
            if (state == BUSY) begin
                // An ack arriving on the last watchdog cycle still counts as success.
                if (mem_ack) begin
                    rdata <= lat_we ? '0 : mem_rd;
                    err   <= 1'b0;
                end else if (timeout_hit) begin
                    rdata <= '0;
                    err   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign mem_we  = mem_en & lat_we;
    assign p0_done = (state == RESP) && !owner;
    assign p1_done = (state == RESP) && owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): arbitration order, latching, watchdog,
// spurious acks and asynchronous reset, with hand-computed expectations.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          p0_req, p0_we, p0_done;
    logic [AW-1:0] p0_adr;
    logic [DW-1:0] p0_wd;
    logic          p1_req, p1_we, p1_done;
    logic [AW-1:0] p1_adr;
    logic [DW-1:0] p1_wd;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          mem_ack;
    logic          owner;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wd(p0_wd), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wd(p1_wd), .p1_done(p1_done),
        .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_ack(mem_ack), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse mem_ack for one cycle; returns in the RESP cycle.
    task automatic ack_now(input logic [DW-1:0] d);
        mem_rd  = d;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_adr = '0; p0_wd = '0;
        p1_req = 0; p1_we = 0; p1_adr = '0; p1_wd = '0;
        mem_rd = '0; mem_ack = 0;

        // Reset state
        tick(); tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_done", {p1_done, p0_done}, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_adr", mem_adr, 0);
        reset = 1'b0;

        // Both request at first IDLE: CPU, then DMA, then CPU
        p0_req = 1; p0_adr = 32'h100;
        p1_req = 1; p1_adr = 32'h200;
        tick();
        chk("rr1_mem_en", mem_en, 1);
        chk("rr1_owner", owner, 0);
        chk("rr1_adr", mem_adr, 32'h100);
        ack_now(32'h11);
        chk("rr1_done", {p1_done, p0_done}, 2'b01);
        chk("rr1_rdata", rdata, 32'h11);
        tick();
        chk("rr_idle_en", mem_en, 0);
        tick();
        chk("rr2_owner", owner, 1);
        chk("rr2_adr", mem_adr, 32'h200);
        ack_now(32'h22);
        chk("rr2_done", {p1_done, p0_done}, 2'b10);
        chk("rr2_rdata", rdata, 32'h22);
        tick(); tick();
        chk("rr3_owner", owner, 0);
        chk("rr3_adr", mem_adr, 32'h100);
        ack_now(32'h33);
        chk("rr3_done", {p1_done, p0_done}, 2'b01);
        p0_req = 0; p1_req = 0;
        tick();
        chk("rr_done_clear", {p1_done, p0_done}, 0);

        // DMA write with inputs changing during BUSY
        p1_req = 1; p1_we = 1; p1_adr = 32'h40; p1_wd = 32'hDEADBEEF;
        tick();
        chk("dw_we", mem_we, 1);
        chk("dw_adr", mem_adr, 32'h40);
        p1_adr = 32'h99; p1_wd = 32'h0; p1_we = 0;
        tick();
        chk("dw_adr_hold", mem_adr, 32'h40);
        chk("dw_wd_hold", mem_wd, 32'hDEADBEEF);
        chk("dw_we_hold", mem_we, 1);
        ack_now(32'h5555);
        chk("dw_done", {p1_done, p0_done}, 2'b10);
        chk("dw_rdata", rdata, 0);
        chk("dw_err", err, 0);
        chk("dw_mem_en_resp", mem_en, 0);
        p1_req = 0;
        tick();

        // CPU-only read, ack two cycles after mem_en rises
        p0_req = 1; p0_we = 0; p0_adr = 32'h10;
        tick();
        chk("c1_en", mem_en, 1);
        chk("c1_adr", mem_adr, 32'h10);
        chk("c1_we", mem_we, 0);
        tick();
        chk("c1_no_done", p0_done, 0);
        tick();
        ack_now(32'hE3A01005);
        chk("c1_done", {p1_done, p0_done}, 2'b01);
        chk("c1_rdata", rdata, 32'hE3A01005);
        chk("c1_err", err, 0);
        p0_req = 0;
        tick();
        chk("c1_done_pulse", p0_done, 0);
        chk("c1_rdata_hold", rdata, 32'hE3A01005);

        // Watchdog: four BUSY cycles with no ack
        p0_req = 1; p0_adr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_en_%0d", i), mem_en, 1);
        end
        tick();
        chk("to_done", {p1_done, p0_done}, 2'b01);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 0);
        chk("to_en_off", mem_en, 0);
        p0_req = 0;
        tick();
        chk("to_err_hold", err, 1);

        // Ack on the fourth BUSY cycle beats the watchdog
        p0_req = 1;
        tick(); tick(); tick(); tick();
        chk("to4_en", mem_en, 1);
        ack_now(32'h77);
        chk("to4_done", p0_done, 1);
        chk("to4_err", err, 0);
        chk("to4_rdata", rdata, 32'h77);
        p0_req = 0;
        tick();

        // Spurious ack in IDLE and RESP
        mem_ack = 1; mem_rd = 32'hBAD;
        tick();
        chk("sp_idle_en", mem_en, 0);
        chk("sp_idle_done", {p1_done, p0_done}, 0);
        tick();
        chk("sp_idle_rdata", rdata, 32'h77);
        mem_ack = 0;
        p1_req = 1; p1_we = 0; p1_adr = 32'h30;
        tick();
        chk("sp_owner", owner, 1);
        ack_now(32'h33);
        chk("sp_resp_done", p1_done, 1);
        mem_ack = 1; mem_rd = 32'hBAD; p1_req = 0;
        tick();
        chk("sp_resp_next_done", {p1_done, p0_done}, 0);
        chk("sp_resp_next_en", mem_en, 0);
        chk("sp_resp_rdata", rdata, 32'h33);
        mem_ack = 0;
        tick();
        chk("sp_stay_idle", mem_en, 0);

        // Reset during BUSY, then tie goes to the CPU
        p0_req = 1; p0_adr = 32'h55;
        tick();
        chk("rb_busy", mem_en, 1);
        #1 reset = 1'b1;
        #1;
        chk("rb_en_async", mem_en, 0);
        chk("rb_done_async", {p1_done, p0_done}, 0);
        p1_req = 1; p1_adr = 32'h66;
        tick();
        chk("rb_no_done", {p1_done, p0_done}, 0);
        chk("rb_rdata", rdata, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rb_owner", owner, 0);
        chk("rb_adr", mem_adr, 32'h55);
        ack_now(32'h88);
        chk("rb_done", {p1_done, p0_done}, 2'b01);
        chk("rb_rdata_new", rdata, 32'h88);
        p0_req = 0; p1_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
